// File: rtl/rstseq_pkg.sv
// Shared types and constants for the reset sequencer.
package rstseq_pkg;

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // Flip-flop depth of the pll_locked synchroniser
    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/rstseq_sync.sv
// Multi-flop synchroniser for a single asynchronous level input.
// Output is forced to 0 while reset is asserted.
module rstseq_sync
    import rstseq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_ff;

    // Shift the async input through the synchroniser chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset tree sequencer: holds all domains in reset for a minimum time and
// until the PLL is stably locked, then releases them one by one. Lock loss
// or a software request re-runs the whole sequence.
// Optional lock-wait watchdog: define RSTSEQ_WDOG_EN.
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_DELAY = 8,
    parameter int unsigned LOCK_FILTER = 4,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   rst_done,
    output logic                   lock_timeout
);

    localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned STAGE_W = $clog2(STAGE_DELAY + 1);
    localparam int unsigned LOCK_W  = $clog2(LOCK_FILTER + 1);
    localparam int unsigned IDX_W   = $clog2(NUM_DOMAINS + 1);

    state_t                 state, state_nxt;
    logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
    logic [STAGE_W-1:0]     stage_cnt, stage_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [NUM_DOMAINS-1:0] rst_nxt;
    logic [LOCK_W-1:0]      lock_cnt;
    logic                   lock_ok;
    logic                   pll_sync;
    logic                   abort;

    rstseq_sync u_pll_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked),
        .q     (pll_sync)
    );

    // Lock filter: saturating run-length of synchronised-high samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (!pll_sync) begin
            lock_cnt <= '0;
        end else if (lock_cnt != LOCK_W'(LOCK_FILTER)) begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
        end
    end

    assign lock_ok = (lock_cnt == LOCK_W'(LOCK_FILTER));

    // State, counters and registered reset outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_HOLD;
            hold_cnt  <= '0;
            stage_cnt <= '0;
            idx       <= '0;
            rst_out   <= '1;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            stage_cnt <= stage_nxt;
            idx       <= idx_nxt;
            rst_out   <= rst_nxt;
        end
    end

    // Next-state and next-counter logic
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        stage_nxt = stage_cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_out;
        abort     = 1'b0;

        unique case (state)
            S_HOLD: begin
                rst_nxt = '1;
                if (hold_cnt != HOLD_W'(HOLD_CYCLES)) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
                if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                rst_nxt = '1;
                if (lock_ok) begin
                    state_nxt  = S_RELEASE;
                    rst_nxt[0] = 1'b0;
                    idx_nxt    = IDX_W'(1);
                    stage_nxt  = '0;
                end
            end
            S_RELEASE: begin
                if (stage_cnt == STAGE_W'(STAGE_DELAY - 1)) begin
                    stage_nxt = '0;
                    if (idx == IDX_W'(NUM_DOMAINS)) begin
                        state_nxt = S_RUN;
                    end else begin
                        // idx is wider than a domain index, so decode it explicitly
                        for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
                            if (idx == IDX_W'(d)) begin
                                rst_nxt[d] = 1'b0;
                            end
                        end
                        idx_nxt = idx + IDX_W'(1);
                    end
                end else begin
                    stage_nxt = stage_cnt + STAGE_W'(1);
                end
            end
            S_RUN: begin
                rst_nxt = '0;
            end
            default: begin
                state_nxt = S_HOLD;
            end
        endcase

        // Lock loss and software request share one abort path, so a
        // coincident pair still produces a single return to S_HOLD
        if (((state == S_RELEASE) || (state == S_RUN)) && !pll_sync) begin
            abort = 1'b1;
        end
        if ((state == S_RUN) && sw_rst_req) begin
            abort = 1'b1;
        end
        if (abort) begin
            state_nxt = S_HOLD;
            rst_nxt   = '1;
            hold_nxt  = '0;
            stage_nxt = '0;
            idx_nxt   = '0;
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        rst_done = (state == S_RUN);
    end

`ifdef RSTSEQ_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt, wdog_nxt;
    logic              timeout_q;

    // Watchdog counts only while staying in S_WAIT_LOCK
    always_comb begin
        wdog_nxt = wdog_cnt;
        if (state_nxt != S_WAIT_LOCK) begin
            wdog_nxt = '0;
        end else if ((state == S_WAIT_LOCK) && (wdog_cnt != WDOG_W'(WDOG_CYCLES))) begin
            wdog_nxt = wdog_cnt + WDOG_W'(1);
        end
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_cnt <= wdog_nxt;
            if (wdog_nxt == WDOG_W'(WDOG_CYCLES)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign lock_timeout = timeout_q;
`else
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: timeline table plus scoreboard.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       sw_rst_req;
    logic [3:0] rst_out;
    logic       rst_done;
    logic       lock_timeout;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS (4),
        .HOLD_CYCLES (16),
        .STAGE_DELAY (8),
        .LOCK_FILTER (4),
        .WDOG_CYCLES (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .sw_rst_req   (sw_rst_req),
        .rst_out      (rst_out),
        .rst_done     (rst_done),
        .lock_timeout (lock_timeout)
    );

    typedef struct {
        int unsigned e;
        logic [3:0]  ro;
        logic        done;
    } vec_t;

    typedef struct {
        int unsigned e;
        logic [3:0]  ro;
        logic        done;
        logic        to;
    } exp_t;

    vec_t        tl[12];
    exp_t        sbq[$];
    int unsigned edge_cnt;
    int          checks;
    int          failures;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, got, exp);
        end
    endtask

    task automatic push1(input int unsigned e, input logic [3:0] ro, input logic done, input logic to);
        exp_t x;
        x.e = e; x.ro = ro; x.done = done; x.to = to;
        sbq.push_back(x);
    endtask

    // Queue the default release timeline, shifted to start at edge 'off'
    task automatic push_tl(input int unsigned off, input int unsigned max_e);
        foreach (tl[i]) begin
            if (tl[i].e <= max_e) push1(tl[i].e + off, tl[i].ro, tl[i].done, 1'b0);
        end
    endtask

    task automatic step();
        exp_t x;
        @(posedge clk);
        #1;
        edge_cnt++;
        while (sbq.size() > 0 && sbq[0].e == edge_cnt) begin
            x = sbq.pop_front();
            chk("rst_out", 32'(rst_out), 32'(x.ro));
            chk("rst_done", 32'(rst_done), 32'(x.done));
            chk("lock_timeout", 32'(lock_timeout), 32'(x.to));
        end
    endtask

    task automatic end_segment(input string name);
        chk({name, " pending_expectations"}, 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic do_reset(input logic pll);
        reset      = 1'b1;
        pll_locked = pll;
        sw_rst_req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset rst_out", 32'(rst_out), 32'hF);
        chk("reset rst_done", 32'(rst_done), 32'd0);
        chk("reset lock_timeout", 32'(lock_timeout), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        edge_cnt = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        edge_cnt = 0;

        tl[0]  = '{1,  4'b1111, 1'b0};
        tl[1]  = '{16, 4'b1111, 1'b0};
        tl[2]  = '{17, 4'b1110, 1'b0};
        tl[3]  = '{24, 4'b1110, 1'b0};
        tl[4]  = '{25, 4'b1100, 1'b0};
        tl[5]  = '{32, 4'b1100, 1'b0};
        tl[6]  = '{33, 4'b1000, 1'b0};
        tl[7]  = '{40, 4'b1000, 1'b0};
        tl[8]  = '{41, 4'b0000, 1'b0};
        tl[9]  = '{48, 4'b0000, 1'b0};
        tl[10] = '{49, 4'b0000, 1'b1};
        tl[11] = '{55, 4'b0000, 1'b1};

        // Default run, then a 1-clock lock drop, then software requests
        do_reset(1'b1);
        push_tl(0, 1000);
        push1(62, 4'b0000, 1'b1, 1'b0);
        push1(63, 4'b1111, 1'b0, 1'b0);
        push_tl(63, 1000);
        push1(120, 4'b0000, 1'b1, 1'b0);
        push1(121, 4'b1111, 1'b0, 1'b0);
        push_tl(121, 1000);
        for (int unsigned n = 1; n <= 176; n++) begin
            step();
            if (edge_cnt == 60)  pll_locked = 1'b0;
            if (edge_cnt == 61)  pll_locked = 1'b1;
            if (edge_cnt == 120) sw_rst_req = 1'b1;
            if (edge_cnt == 121) sw_rst_req = 1'b0;
            if (edge_cnt == 125) sw_rst_req = 1'b1;
            if (edge_cnt == 126) sw_rst_req = 1'b0;
            if (edge_cnt == 140) sw_rst_req = 1'b1;
            if (edge_cnt == 141) sw_rst_req = 1'b0;
        end
        end_segment("lockloss_swreq");

        // Async reset in the middle of S_RELEASE
        do_reset(1'b1);
        push_tl(0, 28);
        for (int unsigned n = 1; n <= 28; n++) step();
        end_segment("pre_abort");
        chk("mid_release rst_out", 32'(rst_out), 32'hC);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst_out", 32'(rst_out), 32'hF);
        chk("async rst_done", 32'(rst_done), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        edge_cnt = 0;
        push_tl(0, 1000);
        for (int unsigned n = 1; n <= 55; n++) step();
        end_segment("restart");

        // Late lock: pll_locked rises after edge 40
        do_reset(1'b0);
        push1(1, 4'b1111, 1'b0, 1'b0);
        push1(20, 4'b1111, 1'b0, 1'b0);
        push_tl(30, 1000);
        for (int unsigned n = 1; n <= 85; n++) begin
            step();
            if (edge_cnt == 40) pll_locked = 1'b1;
        end
        end_segment("late_lock");

`ifdef RSTSEQ_WDOG_EN
        // Watchdog expiry, then a late lock completes the sequence
        do_reset(1'b0);
        push1(16, 4'b1111, 1'b0, 1'b0);
        push1(47, 4'b1111, 1'b0, 1'b0);
        push1(48, 4'b1111, 1'b0, 1'b1);
        push1(50, 4'b1111, 1'b0, 1'b1);
        push1(56, 4'b1111, 1'b0, 1'b1);
        push1(57, 4'b1110, 1'b0, 1'b1);
        push1(88, 4'b0000, 1'b0, 1'b1);
        push1(89, 4'b0000, 1'b1, 1'b1);
        push1(95, 4'b0000, 1'b1, 1'b1);
        for (int unsigned n = 1; n <= 95; n++) begin
            step();
            if (edge_cnt == 50) pll_locked = 1'b1;
        end
        end_segment("wdog");
`else
        // Without the watchdog a long lock wait never flags a timeout
        do_reset(1'b0);
        push1(100, 4'b1111, 1'b0, 1'b0);
        push1(200, 4'b1111, 1'b0, 1'b0);
        for (int unsigned n = 1; n <= 200; n++) step();
        end_segment("no_wdog");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
